forwarding_hazard_controller: RTL

- Sequences the two 3-to-1 operand-select muxes (ForwardA/ForwardB) in the EX stage of the pipelined MIPS core.
- Tracks destination registers of in-flight instructions internally, producing registered 2-bit selectors, one-cycle load-use stalls and bubbles.
- Sits beside the ID/EX pipeline register; driven by decode-stage fields, drives the EX-stage muxes and the PC/IF-ID write enables.

---
 rtl/forwarding_hazard_controller_pkg.sv | 33 +++
 rtl/forwarding_hazard_controller_hazard_stage_tracker.sv | 44 ++++
 rtl/forwarding_hazard_controller.sv | 111 +++++++++++
 3 files changed

// File: rtl/forwarding_hazard_controller_pkg.sv
// rtl/forwarding_hazard_controller_pkg.sv - shared selector codes, FSM states and stage-entry type
package forwarding_hazard_controller_pkg;

  localparam int PKG_REG_ADDR_W = 5;

  localparam logic [1:0] FWD_REGFILE = 2'b00;
  localparam logic [1:0] FWD_MEMWB   = 2'b01;
  localparam logic [1:0] FWD_EXMEM   = 2'b10;

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } hz_state_e;

  typedef struct packed {
    logic [PKG_REG_ADDR_W-1:0] dest;
    logic                      reg_write;
    logic                      mem_read;
  } stage_t;

  localparam stage_t STAGE_BUBBLE = '{dest: '0, reg_write: 1'b0, mem_read: 1'b0};

  // A stage can feed a source operand only if it writes a non-zero register equal to it.
  function automatic logic fwd_match(input stage_t e, input logic [PKG_REG_ADDR_W-1:0] src);
    return e.reg_write && (e.dest != '0) && (e.dest == src);
  endfunction

  // A load in EX blocks any consumer of its destination for one cycle.
  function automatic logic load_hit(input stage_t e, input logic [PKG_REG_ADDR_W-1:0] src);
    return e.mem_read && fwd_match(e, src);
  endfunction

endpackage

// File: rtl/forwarding_hazard_controller_hazard_stage_tracker.sv
// rtl/forwarding_hazard_controller_hazard_stage_tracker.sv - EX/MEM destination shift register with bubble insertion
module hazard_stage_tracker
  import forwarding_hazard_controller_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   enable_i,
  input  logic   load_i,
  input  stage_t id_entry_i,
  output stage_t ex_o,
  output stage_t mem_o,
  output logic   bubble_o
);

  stage_t ex_q, ex_d;
  stage_t mem_q;
  logic   bubble_q;

  // Choose between the decoded instruction and a NOP for the EX slot.
  always_comb begin
    ex_d = STAGE_BUBBLE;
    if (load_i) begin
      ex_d = id_entry_i;
    end
  end

  // Advance EX -> MEM and refill EX on every enabled edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q     <= STAGE_BUBBLE;
      mem_q    <= STAGE_BUBBLE;
      bubble_q <= 1'b0;
    end else if (enable_i) begin
      mem_q    <= ex_q;
      ex_q     <= ex_d;
      bubble_q <= ~load_i;
    end
  end

  assign ex_o     = ex_q;
  assign mem_o    = mem_q;
  assign bubble_o = bubble_q;

endmodule

// File: rtl/forwarding_hazard_controller.sv
// rtl/forwarding_hazard_controller.sv - EX-stage forwarding selectors and load-use stall control; optional HAZARD_COUNTERS_EN adds counters
module forwarding_hazard_controller
  import forwarding_hazard_controller_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int SEL_W      = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  PipeEnable,
  input  logic                  Flush,
  input  logic                  ID_Valid,
  input  logic [REG_ADDR_W-1:0] ID_Rs,
  input  logic [REG_ADDR_W-1:0] ID_Rt,
  input  logic [REG_ADDR_W-1:0] ID_WriteReg,
  input  logic                  ID_RegWrite,
  input  logic                  ID_MemRead,
  output logic [SEL_W-1:0]      ForwardA,
  output logic [SEL_W-1:0]      ForwardB,
  output logic                  Stall,
  output logic                  PC_Write,
  output logic                  IFID_Write,
`ifdef HAZARD_COUNTERS_EN
  output logic [15:0]           StallCount,
  output logic [15:0]           ForwardCount,
`endif
  output logic                  Bubble
);

  hz_state_e        state_q;
  stage_t           ex_entry, mem_entry, id_entry;
  logic             load_ex;
  logic [SEL_W-1:0] fwd_a_q, fwd_a_d;
  logic [SEL_W-1:0] fwd_b_q, fwd_b_d;

  assign id_entry = '{dest: ID_WriteReg, reg_write: ID_RegWrite, mem_read: ID_MemRead};

  // Load-use hazard is only raised from RUN; a flush kills the consumer so no stall is needed.
  always_comb begin
    Stall = 1'b0;
    if ((state_q == RUN) && ID_Valid && !Flush &&
        (load_hit(ex_entry, ID_Rs) || load_hit(ex_entry, ID_Rt))) begin
      Stall = 1'b1;
    end
  end

  assign load_ex = ID_Valid & ~Flush & ~Stall;

  hazard_stage_tracker u_tracker (
    .clk        (clk),
    .reset      (reset),
    .enable_i   (PipeEnable),
    .load_i     (load_ex),
    .id_entry_i (id_entry),
    .ex_o       (ex_entry),
    .mem_o      (mem_entry),
    .bubble_o   (Bubble)
  );

  // Selectors look at today's EX/MEM, which become EX/MEM and MEM/WB when the instruction reaches EX.
  always_comb begin
    fwd_a_d = FWD_REGFILE;
    fwd_b_d = FWD_REGFILE;
    if (fwd_match(ex_entry, ID_Rs))       fwd_a_d = FWD_EXMEM;
    else if (fwd_match(mem_entry, ID_Rs)) fwd_a_d = FWD_MEMWB;
    if (fwd_match(ex_entry, ID_Rt))       fwd_b_d = FWD_EXMEM;
    else if (fwd_match(mem_entry, ID_Rt)) fwd_b_d = FWD_MEMWB;
  end

  // Stall FSM and registered selectors; STALL lasts exactly one enabled cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      fwd_a_q <= FWD_REGFILE;
      fwd_b_q <= FWD_REGFILE;
    end else if (PipeEnable) begin
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
      case (state_q)
        RUN:     state_q <= Stall ? STALL : RUN;
        STALL:   state_q <= RUN;
        default: state_q <= RUN;
      endcase
    end
  end

  assign ForwardA   = fwd_a_q;
  assign ForwardB   = fwd_b_q;
  assign PC_Write   = ~Stall;
  assign IFID_Write = ~Stall;

`ifdef HAZARD_COUNTERS_EN
  logic [15:0] stall_cnt_q, fwd_cnt_q;

  // Saturating event counters, counting only on enabled cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else if (PipeEnable) begin
      if (Stall && (stall_cnt_q != 16'hFFFF)) stall_cnt_q <= stall_cnt_q + 16'd1;
      if (((fwd_a_d != FWD_REGFILE) || (fwd_b_d != FWD_REGFILE)) && (fwd_cnt_q != 16'hFFFF))
        fwd_cnt_q <= fwd_cnt_q + 16'd1;
    end
  end

  assign StallCount   = stall_cnt_q;
  assign ForwardCount = fwd_cnt_q;
`endif

endmodule
